huffman_decoder: RTL and testbench

HUFFMAN_DECODER -- requirements
Module: huffman_decoder

---
 rtl/huffman_pkg.sv | 22 ++
 rtl/huffman_code_table.sv | 83 ++++++++
 rtl/huffman_decoder.sv | 176 +++++++++++++++++
 tb/tb_huffman_decoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// ============================================================================
// Module   : huffman_pkg
// Purpose  : Shared widths and FSM state encodings for the Huffman codec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package huffman_pkg;

  localparam int SYM_W       = 8;   // symbol width in bits
  localparam int CODE_W      = 8;   // longest codeword in bits
  localparam int LEN_W       = 4;   // width of a code-length field
  localparam int TABLE_DEPTH = 16;  // number of code-table entries

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

endpackage : huffman_pkg

`default_nettype wire

// File: rtl/huffman_code_table.sv
// ============================================================================
// Module   : huffman_code_table
// Purpose  : Code-table storage with a single write port and a parallel
//            lookup that reports the lowest-index entry matching a partial
//            codeword of a given length.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module huffman_code_table #(
  parameter int SYM_W       = 8,
  parameter int CODE_W      = 8,
  parameter int LEN_W       = 4,
  parameter int TABLE_DEPTH = 16,
  parameter int IDX_W       = $clog2(TABLE_DEPTH)
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [SYM_W-1:0]  wr_symbol,
  input  logic [LEN_W-1:0]  wr_length,
  input  logic [CODE_W-1:0] wr_code,
  input  logic [CODE_W-1:0] cand_bits,
  input  logic [LEN_W-1:0]  cand_len,
  output logic              hit,
  output logic [SYM_W-1:0]  hit_symbol
);

  import huffman_pkg::*;

  logic [TABLE_DEPTH-1:0] valid;
  logic [SYM_W-1:0]       sym_mem  [TABLE_DEPTH];
  logic [LEN_W-1:0]       len_mem  [TABLE_DEPTH];
  logic [CODE_W-1:0]      code_mem [TABLE_DEPTH];
  logic [CODE_W-1:0]      len_mask;
  logic [TABLE_DEPTH-1:0] match_vec;

  // Entry valid flags; clearing them on reset invalidates the whole table.
  always_ff @(posedge clock) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Entry payload; only meaningful while the matching valid flag is set.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      sym_mem[wr_idx]  <= wr_symbol;
      len_mem[wr_idx]  <= wr_length;
      code_mem[wr_idx] <= wr_code;
    end
  end

  // Only the low cand_len bits of the candidate take part in the compare.
  for (genvar b = 0; b < CODE_W; b++) begin : g_mask
    assign len_mask[b] = (LEN_W'(b) < cand_len);
  end

  // Every entry is compared in parallel against the candidate.
  for (genvar e = 0; e < TABLE_DEPTH; e++) begin : g_entry
    assign match_vec[e] = valid[e]
                        && (len_mem[e] == cand_len)
                        && (((code_mem[e] ^ cand_bits) & len_mask) == '0);
  end

  // Lowest-index matching entry wins.
  always_comb begin
    hit        = 1'b0;
    hit_symbol = '0;
    for (int e = 0; e < TABLE_DEPTH; e++) begin
      if (!hit && match_vec[e]) begin
        hit        = 1'b1;
        hit_symbol = sym_mem[e];
      end
    end
  end

endmodule : huffman_code_table

`default_nettype wire

// File: rtl/huffman_decoder.sv
// ============================================================================
// Module   : huffman_decoder
// Purpose  : Bit-serial Huffman decoder. A code table is loaded one entry per
//            cycle, then the coded stream is consumed one bit per cycle and
//            each completed codeword is presented as a symbol with a
//            valid/ready handshake. Malformed tables or streams latch err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module huffman_decoder #(
  parameter int SYM_W       = huffman_pkg::SYM_W,
  parameter int CODE_W      = huffman_pkg::CODE_W,
  parameter int TABLE_DEPTH = huffman_pkg::TABLE_DEPTH
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              tbl_valid,
  input  logic [SYM_W-1:0]  tbl_symbol,
  input  logic [3:0]        tbl_length,
  input  logic [CODE_W-1:0] tbl_code,
  input  logic              tbl_done,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              bit_ready,
  output logic              sym_valid,
  output logic [SYM_W-1:0]  sym_out,
  input  logic              sym_ready,
  output logic [15:0]       sym_count,
  output logic              err,
  output logic [1:0]        out_state
);

  import huffman_pkg::*;

  localparam int IDX_W = $clog2(TABLE_DEPTH);
  localparam int CNT_W = $clog2(TABLE_DEPTH + 1);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TABLE_DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(CODE_W);
  localparam logic [LEN_W-1:0] LAST_N   = LEN_W'(CODE_W - 1);

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [CNT_W-1:0]  entry_cnt;
  logic [LEN_W-1:0]  n;
  logic [CODE_W-1:0] acc;
  logic [CODE_W-1:0] cand_bits;
  logic [LEN_W-1:0]  cand_len;
  logic              entry_ok;
  logic              table_full;
  logic              tbl_wr;
  logic              bit_take;
  logic              hit;
  logic [SYM_W-1:0]  hit_symbol;

  // Qualify table writes and build the candidate codeword for this bit.
  always_comb begin
    entry_ok   = tbl_valid && (tbl_length != 4'd0) && (tbl_length <= MAX_LEN);
    table_full = (entry_cnt == FULL_CNT);
    tbl_wr     = (state == ST_LOAD) && entry_ok && !table_full;
    bit_take   = (state == ST_DECODE) && bit_valid;
    cand_len   = n + LEN_W'(1);
    cand_bits  = acc;
    for (int i = 0; i < CODE_W; i++) begin
      if (LEN_W'(i) == n) begin
        cand_bits[i] = bit_in;
      end
    end
  end

  huffman_code_table #(
    .SYM_W       (SYM_W),
    .CODE_W      (CODE_W),
    .LEN_W       (LEN_W),
    .TABLE_DEPTH (TABLE_DEPTH),
    .IDX_W       (IDX_W)
  ) u_table (
    .clock      (clock),
    .rst        (rst),
    .wr_en      (tbl_wr),
    .wr_idx     (entry_cnt[IDX_W-1:0]),
    .wr_symbol  (tbl_symbol),
    .wr_length  (tbl_length),
    .wr_code    (tbl_code),
    .cand_bits  (cand_bits),
    .cand_len   (cand_len),
    .hit        (hit),
    .hit_symbol (hit_symbol)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; a same-cycle entry counts toward the tbl_done check.
  always_comb begin
    state_nx = state;
    case (state)
      ST_LOAD: begin
        if (entry_ok && table_full) begin
          state_nx = ST_ERROR;
        end else if (tbl_done) begin
          state_nx = (tbl_wr || (entry_cnt != '0)) ? ST_DECODE : ST_ERROR;
        end
      end
      ST_DECODE: begin
        if (bit_take) begin
          if (hit) begin
            state_nx = ST_EMIT;
          end else if (n == LAST_N) begin
            state_nx = ST_ERROR;
          end
        end
      end
      ST_EMIT: begin
        if (sym_ready) begin
          state_nx = ST_DECODE;
        end
      end
      ST_ERROR: begin
        state_nx = ST_ERROR;
      end
      default: begin
        state_nx = ST_LOAD;
      end
    endcase
  end

  // Handshake outputs follow directly from the current state.
  always_comb begin
    bit_ready = (state == ST_DECODE);
    sym_valid = (state == ST_EMIT);
    out_state = state;
  end

  // Datapath: entry counter, bit accumulator, symbol register, counters, err.
  always_ff @(posedge clock) begin
    if (rst) begin
      entry_cnt <= '0;
      n         <= '0;
      acc       <= '0;
      sym_out   <= '0;
      sym_count <= '0;
      err       <= 1'b0;
    end else begin
      if (tbl_wr) begin
        entry_cnt <= entry_cnt + CNT_W'(1);
      end
      if ((state_nx == ST_ERROR) && (state != ST_ERROR)) begin
        err <= 1'b1;
      end
      if (bit_take) begin
        if (hit) begin
          sym_out <= hit_symbol;
          n       <= '0;
          acc     <= '0;
        end else if (n != LAST_N) begin
          acc <= cand_bits;
          n   <= cand_len;
        end
      end
      if ((state == ST_EMIT) && sym_ready) begin
        sym_count <= sym_count + 16'd1;
      end
    end
  end

endmodule : huffman_decoder

`default_nettype wire

// File: tb/tb_huffman_decoder.sv
// ============================================================================
// Module   : tb_huffman_decoder
// Purpose  : Directed self-checking bench for huffman_decoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_huffman_decoder;

  logic        clock;
  logic        rst;
  logic        tbl_valid;
  logic [7:0]  tbl_symbol;
  logic [3:0]  tbl_length;
  logic [7:0]  tbl_code;
  logic        tbl_done;
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        sym_valid;
  logic [7:0]  sym_out;
  logic        sym_ready;
  logic [15:0] sym_count;
  logic        err;
  logic [1:0]  out_state;

  int total = 0;
  int bad   = 0;

  huffman_decoder dut (
    .clock      (clock),
    .rst        (rst),
    .tbl_valid  (tbl_valid),
    .tbl_symbol (tbl_symbol),
    .tbl_length (tbl_length),
    .tbl_code   (tbl_code),
    .tbl_done   (tbl_done),
    .bit_valid  (bit_valid),
    .bit_in     (bit_in),
    .bit_ready  (bit_ready),
    .sym_valid  (sym_valid),
    .sym_out    (sym_out),
    .sym_ready  (sym_ready),
    .sym_count  (sym_count),
    .err        (err),
    .out_state  (out_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_entry(input logic [7:0] s, input logic [3:0] l, input logic [7:0] c);
    tbl_valid  = 1'b1;
    tbl_symbol = s;
    tbl_length = l;
    tbl_code   = c;
    tick();
    tbl_valid  = 1'b0;
  endtask

  task automatic pulse_done();
    tbl_done = 1'b1;
    tick();
    tbl_done = 1'b0;
  endtask

  task automatic load_abc();
    load_entry(8'h41, 4'd1, 8'h00);
    load_entry(8'h42, 4'd2, 8'h01);
    load_entry(8'h43, 4'd2, 8'h03);
  endtask

  task automatic send_bit(input logic b);
    int w;
    w = 0;
    while (!bit_ready && w < 20) begin
      tick();
      w++;
    end
    check("bit_ready_wait", {31'd0, bit_ready}, 32'd1);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic ack();
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tbl_valid = 1'b0; tbl_symbol = '0; tbl_length = '0; tbl_code = '0;
    tbl_done = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; sym_ready = 1'b0;
    tick();
    tick();
    check("rst_state",     32'(out_state), 32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_sym_valid", 32'(sym_valid), 32'd0);
    check("rst_bit_ready", 32'(bit_ready), 32'd0);
    check("rst_sym_count", 32'(sym_count), 32'd0);
    check("rst_sym_out",   32'(sym_out),   32'd0);
    rst = 1'b0;

    // Three-symbol table, stream 0,1,0,1,1 with a 5-cycle stall after the first symbol
    load_abc();
    check("load_state", 32'(out_state), 32'd0);
    pulse_done();
    check("decode_state", 32'(out_state), 32'd1);
    check("decode_ready", 32'(bit_ready), 32'd1);
    send_bit(1'b0);
    check("sym1_valid", 32'(sym_valid), 32'd1);
    check("sym1_out",   32'(sym_out),   32'h41);
    check("sym1_state", 32'(out_state), 32'd2);
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_sym_out",   32'(sym_out),   32'h41);
      check("stall_bit_ready", 32'(bit_ready), 32'd0);
      check("stall_sym_valid", 32'(sym_valid), 32'd1);
    end
    sym_ready = 1'b1;
    tick();
    sym_ready = 1'b0;
    check("ack1_count",     32'(sym_count), 32'd1);
    check("ack1_state",     32'(out_state), 32'd1);
    check("ack1_sym_valid", 32'(sym_valid), 32'd0);
    tick();
    check("mid_code_state", 32'(out_state), 32'd1);
    bit_in = 1'b0;
    tick();
    bit_valid = 1'b0;
    check("sym2_valid", 32'(sym_valid), 32'd1);
    check("sym2_out",   32'(sym_out),   32'h42);
    ack();
    send_bit(1'b1);
    send_bit(1'b1);
    check("sym3_out", 32'(sym_out), 32'h43);
    ack();
    check("count3", 32'(sym_count), 32'd3);
    check("clean_err", 32'(err), 32'd0);

    // Unmatched stream of eight 1s
    do_reset();
    load_entry(8'h41, 4'd1, 8'h00);
    pulse_done();
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("seven_state", 32'(out_state), 32'd1);
    check("seven_err",   32'(err),       32'd0);
    send_bit(1'b1);
    check("eight_state", 32'(out_state), 32'd3);
    check("eight_err",   32'(err),       32'd1);
    check("eight_ready", 32'(bit_ready), 32'd0);
    tbl_valid = 1'b1; tbl_length = 4'd1; tbl_done = 1'b1; bit_valid = 1'b1; sym_ready = 1'b1;
    tick();
    tbl_valid = 1'b0; tbl_done = 1'b0; bit_valid = 1'b0; sym_ready = 1'b0;
    check("err_hold_state", 32'(out_state), 32'd3);
    check("err_hold_valid", 32'(sym_valid), 32'd0);
    check("err_hold_ready", 32'(bit_ready), 32'd0);

    // Table overflow on the 17th valid entry
    do_reset();
    check("reset_clears_err", 32'(err), 32'd0);
    for (int i = 0; i < 16; i++) load_entry(8'(i), 4'd4, 8'(i));
    check("full_err",   32'(err),       32'd0);
    check("full_state", 32'(out_state), 32'd0);
    load_entry(8'hAA, 4'd4, 8'h00);
    check("ovf_err",   32'(err),       32'd1);
    check("ovf_state", 32'(out_state), 32'd3);

    // tbl_done with an empty table
    do_reset();
    pulse_done();
    check("empty_err",   32'(err),       32'd1);
    check("empty_state", 32'(out_state), 32'd3);

    // Lengths 0 and 9 are discarded, leaving the table empty
    do_reset();
    load_entry(8'h50, 4'd0, 8'h00);
    load_entry(8'h51, 4'd9, 8'h01);
    check("discard_err",   32'(err),       32'd0);
    check("discard_state", 32'(out_state), 32'd0);
    pulse_done();
    check("discard_done_state", 32'(out_state), 32'd3);

    // Reset in the middle of a 2-bit code
    do_reset();
    load_abc();
    pulse_done();
    send_bit(1'b0);
    ack();
    send_bit(1'b1);
    check("pre_rst_state", 32'(out_state), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", 32'(out_state), 32'd0);
    check("mid_rst_err",   32'(err),       32'd0);
    check("mid_rst_valid", 32'(sym_valid), 32'd0);
    check("mid_rst_ready", 32'(bit_ready), 32'd0);
    check("mid_rst_count", 32'(sym_count), 32'd0);
    check("mid_rst_out",   32'(sym_out),   32'd0);
    pulse_done();
    check("table_gone_state", 32'(out_state), 32'd3);

    // Reload with entry and tbl_done in the same cycle, then decode normally
    do_reset();
    tbl_valid = 1'b1; tbl_symbol = 8'h42; tbl_length = 4'd2; tbl_code = 8'h01; tbl_done = 1'b1;
    tick();
    tbl_valid = 1'b0; tbl_done = 1'b0;
    check("same_cycle_state", 32'(out_state), 32'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    check("reload_sym", 32'(sym_out), 32'h42);
    ack();
    check("reload_count", 32'(sym_count), 32'd1);

    // Duplicate codes: lowest index wins
    do_reset();
    load_entry(8'h60, 4'd1, 8'h01);
    load_entry(8'h61, 4'd1, 8'h01);
    pulse_done();
    send_bit(1'b1);
    check("priority_sym", 32'(sym_out), 32'h60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_huffman_decoder

`default_nettype wire
